// File: rtl/pipe_barrier.sv
// pipe_barrier: two-entry skid buffer placed between pipeline stages.
// Holds up to two payloads (main + skid). in_ready comes straight from a
// register so the upstream handshake never sees the downstream out_ready.
// Optional build macro PIPE_BARRIER_STATS_EN adds the saturating stall_cnt and
// bubble_cnt counters and their output ports.
module pipe_barrier #(
   parameter int PAYLOAD_W = 96,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 out_ready,
   input  logic                 flush,
`ifdef PIPE_BARRIER_STATS_EN
   output logic [XLEN-1:0]      stall_cnt,
   output logic [XLEN-1:0]      bubble_cnt,
`endif
   output logic [1:0]           occupancy
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state_reg;
   logic [PAYLOAD_W-1:0] main_reg;
   logic [PAYLOAD_W-1:0] skid_reg;
   logic                 in_ready_reg;
   logic                 out_valid_reg;
   logic                 push;
   logic                 pop;

   assign push      = in_valid && in_ready_reg;
   assign pop       = out_valid_reg && out_ready;
   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = main_reg;
   assign occupancy = state_reg;

   // Buffer FSM: state, payload registers and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         main_reg      <= '0;
         skid_reg      <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else if (flush) begin
         // Flush wins over any push or pop in the same cycle; the
         // payload registers keep stale data but nothing is valid.
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (push) begin
                  main_reg      <= in_data;
                  state_reg     <= ONE;
                  out_valid_reg <= 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid_reg     <= in_data;
                  state_reg    <= FULL;
                  in_ready_reg <= 1'b0;
               end else if (push && pop) begin
                  main_reg <= in_data;
               end else if (pop) begin
                  state_reg     <= EMPTY;
                  out_valid_reg <= 1'b0;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  main_reg     <= skid_reg;
                  state_reg    <= ONE;
                  in_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_BARRIER_STATS_EN
   logic [XLEN-1:0] stall_cnt_reg;
   logic [XLEN-1:0] bubble_cnt_reg;

   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;

   // Saturating counters of upstream stalls and downstream bubbles; flush
   // intentionally leaves them alone so they span pipeline redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else begin
         if (in_valid && !in_ready_reg && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (out_ready && !out_valid_reg && (bubble_cnt_reg != '1))
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_barrier.sv
// tb_pipe_barrier: directed and random checks of pipe_barrier against a
// queue-based reference model (capacity two, FIFO order, flush empties).
// Define PIPE_BARRIER_STATS_EN to also check the statistics counters.
module tb_pipe_barrier;
   localparam int PW   = 96;
   localparam int XL   = 4;
   localparam int SMAX = (1 << XL) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    occupancy;
`ifdef PIPE_BARRIER_STATS_EN
   logic [XL-1:0] stall_cnt;
   logic [XL-1:0] bubble_cnt;
`endif

   pipe_barrier #(.PAYLOAD_W(PW), .XLEN(XL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush),
`ifdef PIPE_BARRIER_STATS_EN
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt),
`endif
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [PW-1:0] q[$];
   int            exp_stall  = 0;
   int            exp_bubble = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every observable output with the model.
   task automatic check_state(input string tag);
      check({tag, ".occupancy"}, 128'(occupancy), 128'(q.size()));
      check({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
      check({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
      if (q.size() > 0) check({tag, ".out_data"}, 128'(out_data), 128'(q[0]));
`ifdef PIPE_BARRIER_STATS_EN
      check({tag, ".stall_cnt"},  128'(stall_cnt),  128'(exp_stall));
      check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(exp_bubble));
`endif
   endtask

   // One clock cycle: drive inputs after the falling edge, advance the
   // model across the rising edge, check at the next falling edge.
   task automatic step(input logic iv, input logic [PW-1:0] id, input logic ordy,
                       input logic fl, input string tag);
      bit can_push, has_out, do_push, do_pop;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      can_push  = (q.size() < 2);
      has_out   = (q.size() > 0);
      do_push   = iv && can_push;
      do_pop    = has_out && ordy;
      if (iv && !can_push && exp_stall < SMAX) exp_stall++;
      if (ordy && !has_out && exp_bubble < SMAX) exp_bubble++;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(id);
      end
      @(negedge clk);
      check_state(tag);
   endtask

   initial begin
      logic [PW-1:0] rd;
      // Reset state, asynchronously applied before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst.out_valid", 128'(out_valid), 128'(0));
      check("rst.in_ready",  128'(in_ready),  128'(1));
      check("rst.occupancy", 128'(occupancy), 128'(0));
      check("rst.out_data",  128'(out_data),  128'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_state("post_rst");

      // Streaming: one push and one pop per cycle, one cycle latency.
      for (int i = 1; i <= 8; i++) begin
         check("stream.in_ready_pre", 128'(in_ready), 128'(1));
         step(1'b1, PW'(i), 1'b1, 1'b0, "stream");
         check("stream.data", 128'(out_data), 128'(i));
      end
      step(1'b0, '0, 1'b1, 1'b0, "stream_drain");

      // Backpressure: A and B fill the buffer, C is held until space.
      step(1'b1, PW'('hA), 1'b0, 1'b0, "bp_a");
      step(1'b1, PW'('hB), 1'b0, 1'b0, "bp_b");
      check("bp.full_occ", 128'(occupancy), 128'(2));
      check("bp.full_rdy", 128'(in_ready), 128'(0));
      step(1'b1, PW'('hC), 1'b0, 1'b0, "bp_hold");
      check("bp.head_a", 128'(out_data), 128'('hA));
      step(1'b1, PW'('hC), 1'b1, 1'b0, "bp_pop_a");
      check("bp.head_b", 128'(out_data), 128'('hB));
      step(1'b1, PW'('hC), 1'b1, 1'b0, "bp_pop_b_push_c");
      check("bp.head_c", 128'(out_data), 128'('hC));
      step(1'b0, '0, 1'b1, 1'b0, "bp_pop_c");

      // Flush in FULL with a simultaneous push of D.
      step(1'b1, PW'('h11), 1'b0, 1'b0, "fl_fill1");
      step(1'b1, PW'('h22), 1'b0, 1'b0, "fl_fill2");
      step(1'b1, PW'('hD), 1'b0, 1'b1, "flush");
      check("flush.occ", 128'(occupancy), 128'(0));
      check("flush.ov",  128'(out_valid), 128'(0));
      check("flush.rdy", 128'(in_ready),  128'(1));
      step(1'b0, '0, 1'b1, 1'b0, "post_flush");
      check("flush.no_d", 128'(out_valid), 128'(0));

      // Reset asserted mid-cycle while one entry is held.
      step(1'b1, PW'('hE), 1'b0, 1'b0, "rst_fill");
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst.out_valid", 128'(out_valid), 128'(0));
      check("arst.occ",       128'(occupancy), 128'(0));
      check("arst.in_ready",  128'(in_ready),  128'(1));
      check("arst.out_data",  128'(out_data),  128'(0));
      q.delete();
      exp_stall  = 0;
      exp_bubble = 0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, PW'('hF), 1'b0, 1'b0, "arst_first_push");
      check("arst.first", 128'(out_data), 128'('hF));

      // Stall and bubble counting (counters start from the reset above).
      step(1'b1, PW'('h10), 1'b0, 1'b0, "stat_fill");
      for (int i = 0; i < 5; i++) step(1'b1, PW'('h99), 1'b0, 1'b0, "stat_stall");
`ifdef PIPE_BARRIER_STATS_EN
      check("stat.stall5", 128'(stall_cnt), 128'(5));
`endif
      step(1'b0, '0, 1'b1, 1'b0, "stat_pop1");
      step(1'b0, '0, 1'b1, 1'b0, "stat_pop2");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "stat_idle");
`ifdef PIPE_BARRIER_STATS_EN
      check("stat.bubble3", 128'(bubble_cnt), 128'(3));
      // Drive both counters well past all-ones (flush must not clear them).
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'(i == 3), "stat_bsat");
      check("stat.bubble_sat", 128'(bubble_cnt), 128'(SMAX));
      step(1'b1, PW'('h1), 1'b0, 1'b0, "stat_sfill1");
      step(1'b1, PW'('h2), 1'b0, 1'b0, "stat_sfill2");
      for (int i = 0; i < 20; i++) step(1'b1, PW'('h3), 1'b0, 1'b0, "stat_ssat");
      check("stat.stall_sat", 128'(stall_cnt), 128'(SMAX));
      step(1'b0, '0, 1'b0, 1'b1, "stat_flush");
`endif

      // Random valid/ready/flush traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         rd = {$urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
